// File: rtl/delay_line_seq_ctrl.sv
// Write-slot / read-tap sequencer for the register_delay datapath.
// Produces sel_reg/sel_mux so the datapath output is the sample accepted D accepts earlier.
module delay_line_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PTR_W-1:0] cfg_delay,
  output logic             cfg_err,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             wr_en,
  output logic [PTR_W-1:0] sel_reg,
  output logic [PTR_W-1:0] sel_mux,
  output logic             out_valid,
  output logic [PTR_W-1:0] fill,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam logic [PTR_W-1:0] FILL_MAX = PTR_W'(DEPTH - 1);

  state_t           state, state_next;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] d_reg;
  logic [PTR_W-1:0] d_eff;
  logic [PTR_W-1:0] fill_next;
  logic             accept;
  logic             cfg_legal;

  assign cfg_legal = cfg_load && (cfg_delay != '0);
  assign d_eff     = cfg_legal ? cfg_delay : d_reg;

  // In RUN the controller only accepts when downstream can take the delayed sample.
  assign in_ready  = (state == FILL) || ((state == RUN) && out_ready);
  assign accept    = in_valid && in_ready;
  assign wr_en     = accept;
  assign out_valid = accept && (fill >= d_reg);
  assign sel_reg   = wr_ptr;
  assign sel_mux   = wr_ptr - d_reg;
  assign busy      = (state != IDLE);

  always_comb begin
    fill_next  = fill;
    state_next = state;
    if (accept && (fill != FILL_MAX))
      fill_next = fill + PTR_W'(1);
    if (flush && (state != IDLE))
      fill_next = '0;

    // Transitions look at the post-update fill and the delay that will be in force next cycle.
    case (state)
      IDLE: if (cfg_legal) state_next = FILL;
      FILL: begin
        if (flush)                   state_next = FILL;
        else if (fill_next >= d_eff) state_next = RUN;
      end
      RUN: begin
        if (flush)                              state_next = FILL;
        else if (cfg_legal && (d_eff > fill_next)) state_next = FILL;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      d_reg   <= PTR_W'(1);
      fill    <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_next;
      fill    <= fill_next;
      cfg_err <= cfg_load && (cfg_delay == '0);
      if (accept)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (cfg_legal)
        d_reg <= cfg_delay;
    end
  end

endmodule

// File: tb/tb_delay_line_seq_ctrl.sv
// Bench for delay_line_seq_ctrl: hand-derived vector table, directed corner sequences,
// and randomized traffic against a behavioural model of accepted-sample history.
module tb_delay_line_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfg_load, flush, in_valid, out_ready;
  logic [2:0] cfg_delay;
  logic       cfg_err, in_ready, wr_en, out_valid, busy;
  logic [2:0] sel_reg, sel_mux, fill;

  delay_line_seq_ctrl #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_delay(cfg_delay), .cfg_err(cfg_err),
    .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
    .wr_en(wr_en), .sel_reg(sel_reg), .sel_mux(sel_mux), .out_valid(out_valid),
    .fill(fill), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 filling, 2 running; n counts accepts modulo 8.
  int   m_mode, m_n, m_fill, m_d;
  bit   m_err, m_valid = 0;
  int   hist[$];
  logic [7:0] mem [8];
  logic [7:0] sample;
  bit   p_acc, dut_we;
  logic [2:0] dut_slot;

  typedef struct {
    int rst, cfg_load, cfg_delay, flush, in_valid, out_ready;
    int e_ir, e_ov, e_sr, e_sm, e_fill, e_busy, e_err;
  } vec_t;
  vec_t tbl [17];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit cl, input int cd, input bit fl,
                               input bit iv, input bit orr);
    bit p_ir, p_ov;
    int want;
    @(negedge clk);
    rst = r; cfg_load = cl; cfg_delay = 3'(cd); flush = fl; in_valid = iv; out_ready = orr;
    sample = 8'($urandom);
    #1;
    p_ir  = (m_mode == 1) || ((m_mode == 2) && orr);
    p_acc = iv && p_ir;
    p_ov  = p_acc && (m_fill >= m_d);
    dut_we   = wr_en;
    dut_slot = sel_reg;
    if (m_valid) begin
      checkOutput("model in_ready", int'(in_ready), int'(p_ir));
      checkOutput("model wr_en", int'(wr_en), int'(p_acc));
      checkOutput("model out_valid", int'(out_valid), int'(p_ov));
      checkOutput("model sel_reg", int'(sel_reg), m_n);
      checkOutput("model sel_mux", int'(sel_mux), (m_n - m_d + 8) % 8);
      checkOutput("model fill", int'(fill), m_fill);
      checkOutput("model busy", int'(busy), int'(m_mode != 0));
      checkOutput("model cfg_err", int'(cfg_err), int'(m_err));
      if (p_ov && out_valid && hist.size() >= m_d) begin
        want = hist[hist.size() - m_d];
        checkOutput("delayed data", int'(mem[sel_mux]), want);
      end
    end
  endtask

  task automatic advance();
    bit legal;
    int nf, nd;
    @(posedge clk);
    if (dut_we) mem[dut_slot] = sample;
    if (rst) begin
      m_mode = 0; m_n = 0; m_fill = 0; m_d = 1; m_err = 0;
      hist.delete();
      m_valid = 1;
    end else if (m_valid) begin
      legal = cfg_load && (cfg_delay != 0);
      m_err = cfg_load && (cfg_delay == 0);
      nf = m_fill;
      if (p_acc) begin
        hist.push_back(int'(sample));
        m_n = (m_n + 1) % 8;
        nf = (m_fill + 1 > 7) ? 7 : m_fill + 1;
      end
      if (flush && m_mode != 0) nf = 0;
      nd = legal ? int'(cfg_delay) : m_d;
      if (m_mode == 0)      m_mode = legal ? 1 : 0;
      else if (flush)       m_mode = 1;
      else if (m_mode == 1) m_mode = (nf >= nd) ? 2 : 1;
      else                  m_mode = (legal && nd > nf) ? 1 : 2;
      m_fill = nf;
      m_d = nd;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int first;
    //            rst cl cd fl iv or | ir ov sr sm fill busy err
    tbl[0]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 7, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 1, 1,  0, 0, 0, 7, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0,  0, 0, 0, 7, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 7, 0, 0, 1};
    tbl[4]  = '{0, 1, 3, 0, 1, 1,  0, 0, 0, 7, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 1, 1,  1, 0, 0, 5, 0, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 1,  1, 0, 1, 6, 1, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 1,  1, 0, 2, 7, 2, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 1,  1, 1, 3, 0, 3, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 1,  1, 1, 4, 1, 4, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 1, 1,  1, 1, 5, 2, 5, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 1, 1,  1, 1, 6, 3, 6, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 1, 1,  1, 1, 7, 4, 7, 1, 0};
    tbl[13] = '{0, 0, 0, 0, 1, 1,  1, 1, 0, 5, 7, 1, 0};
    tbl[14] = '{0, 1, 0, 0, 0, 1,  1, 0, 1, 6, 7, 1, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 6, 7, 1, 1};
    tbl[16] = '{0, 0, 0, 0, 1, 0,  0, 0, 1, 6, 7, 1, 0};

    applyStimulus(1, 0, 0, 0, 0, 0);
    advance();

    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].rst[0], tbl[i].cfg_load[0], tbl[i].cfg_delay, tbl[i].flush[0],
                    tbl[i].in_valid[0], tbl[i].out_ready[0]);
      checkOutput($sformatf("tbl%0d in_ready", i), int'(in_ready), tbl[i].e_ir);
      checkOutput($sformatf("tbl%0d out_valid", i), int'(out_valid), tbl[i].e_ov);
      checkOutput($sformatf("tbl%0d sel_reg", i), int'(sel_reg), tbl[i].e_sr);
      checkOutput($sformatf("tbl%0d sel_mux", i), int'(sel_mux), tbl[i].e_sm);
      checkOutput($sformatf("tbl%0d fill", i), int'(fill), tbl[i].e_fill);
      checkOutput($sformatf("tbl%0d busy", i), int'(busy), tbl[i].e_busy);
      checkOutput($sformatf("tbl%0d cfg_err", i), int'(cfg_err), tbl[i].e_err);
      advance();
    end

    // Stall held a few more cycles, then resume with exact continuation.
    for (int i = 0; i < 4; i++) begin applyStimulus(0, 0, 0, 0, 1, 0); advance(); end
    for (int i = 0; i < 3; i++) begin applyStimulus(0, 0, 0, 0, 1, 1); advance(); end

    // Reconfigure to D=5 while full: must stay in RUN.
    applyStimulus(0, 1, 5, 0, 1, 1); advance();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t5 in_ready stays RUN", int'(in_ready), 0);
    checkOutput("t5 busy", int'(busy), 1);
    advance();

    // Flush together with D=7: first valid output on the 8th accept.
    applyStimulus(0, 1, 7, 1, 0, 1); advance();
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0, 0, 0, 1, 1);
      if (out_valid && first == 0) first = k;
      advance();
    end
    checkOutput("t5 first out_valid accept", first, 8);

    // Flush and accept in the same cycle: fill ends at zero in FILL.
    applyStimulus(0, 0, 0, 1, 1, 1); advance();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t6 fill after flush", int'(fill), 0);
    checkOutput("t6 in_ready in FILL", int'(in_ready), 1);
    advance();
    applyStimulus(0, 1, 1, 0, 1, 1); advance();
    for (int i = 0; i < 3; i++) begin applyStimulus(0, 0, 0, 0, 1, 1); advance(); end
    applyStimulus(1, 0, 0, 0, 1, 1); advance();
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("t6 rst sel_reg", int'(sel_reg), 0);
    checkOutput("t6 rst sel_mux", int'(sel_mux), 7);
    checkOutput("t6 rst in_ready", int'(in_ready), 0);
    checkOutput("t6 rst out_valid", int'(out_valid), 0);
    checkOutput("t6 rst fill", int'(fill), 0);
    checkOutput("t6 rst busy", int'(busy), 0);
    advance();

    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 127) == 0), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0),
                    1'($urandom), ($urandom_range(0, 3) != 0));
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
